// File: rtl/t03_video_pkg.sv
// t03_video_pkg: default 800x600 timing constants, derived totals and FSM state encoding
package t03_video_pkg;
  localparam int CW = 11;
  localparam int DEF_H_ACTIVE = 800;
  localparam int DEF_H_FP = 56;
  localparam int DEF_H_SYNC = 120;
  localparam int DEF_H_BP = 64;
  localparam int DEF_V_ACTIVE = 600;
  localparam int DEF_V_FP = 37;
  localparam int DEF_V_SYNC = 6;
  localparam int DEF_V_BP = 23;
  localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN = 2'd1;
  localparam state_t ST_STOP = 2'd2;
  function automatic logic in_win(logic [CW-1:0] c, int lo, int len);
    return c >= CW'(lo) && c <= CW'(lo + len - 1);
  endfunction
endpackage

// File: rtl/t03_timing_axis_counter.sv
// t03_timing_axis_counter: one raster axis, advancing on request and wrapping after MAX
module t03_timing_axis_counter import t03_video_pkg::*; #(
  parameter int MAX = DEF_H_TOTAL - 1
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          adv,
  output logic [CW-1:0] count,
  output logic [CW-1:0] count_nxt,
  output logic          tc
);
  localparam logic [CW-1:0] MAXV = CW'(MAX);
  assign tc = count == MAXV;
  assign count_nxt = adv ? (tc ? '0 : count + CW'(1)) : count;
  // Count register; cleared by reset and otherwise follows the advance/wrap decode
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) count <= '0;
    else count <= count_nxt;
endmodule

// File: rtl/t03_display_timing_ctrl.sv
// t03_display_timing_ctrl: raster timing generator with registered syncs aligned to x/y
module t03_display_timing_ctrl import t03_video_pkg::*; #(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic SYNC_POL = 1'b1
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        en,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic        blank,
  output logic        line_end,
  output logic        frame_start,
  output logic        busy
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_total_check
    $error("t03_display_timing_ctrl: H_TOTAL and V_TOTAL must not exceed 2048");
  end
  state_t st, st_nxt;
  logic run, act, de_nxt, h_tc, v_tc;
  logic [CW-1:0] x_nxt, y_nxt;
  assign run = st != ST_IDLE;
  t03_timing_axis_counter #(.MAX(H_TOTAL - 1)) u_h (
    .clk(clk), .nrst(nrst), .adv(run), .count(x), .count_nxt(x_nxt), .tc(h_tc)
  );
  t03_timing_axis_counter #(.MAX(V_TOTAL - 1)) u_v (
    .clk(clk), .nrst(nrst), .adv(run && h_tc), .count(y), .count_nxt(y_nxt), .tc(v_tc)
  );
  // STOP keeps counting until the frame's last pixel; a renewed en resumes RUN in place
  always_comb
    st_nxt = st == ST_IDLE ? (en ? ST_RUN : ST_IDLE)
           : en ? ST_RUN
           : (st == ST_RUN || !(h_tc && v_tc)) ? ST_STOP : ST_IDLE;
  assign act = st_nxt != ST_IDLE;
  assign de_nxt = act && x_nxt < CW'(H_ACTIVE) && y_nxt < CW'(V_ACTIVE);
  // Outputs decoded from next-state/next-count so they land in the same cycle as x/y
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      st <= ST_IDLE;
      hsync <= ~SYNC_POL;
      vsync <= ~SYNC_POL;
      de <= 1'b0;
      blank <= 1'b1;
      line_end <= 1'b0;
      frame_start <= 1'b0;
      busy <= 1'b0;
    end else begin
      st <= st_nxt;
      hsync <= (act && in_win(x_nxt, H_ACTIVE + H_FP, H_SYNC)) ? SYNC_POL : ~SYNC_POL;
      vsync <= (act && in_win(y_nxt, V_ACTIVE + V_FP, V_SYNC)) ? SYNC_POL : ~SYNC_POL;
      de <= de_nxt;
      blank <= ~de_nxt;
      line_end <= act && x_nxt == CW'(H_TOTAL - 1);
      frame_start <= act && x_nxt == '0 && y_nxt == '0;
      busy <= act;
    end
endmodule

// File: tb/tb_t03_display_timing_ctrl.sv
// tb_t03_display_timing_ctrl: table vectors, corner sequences and random en against a raster model
module tb_t03_display_timing_ctrl;
  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic hs, vs, de, bl, le, fs, busy;
  } obs_t;
  typedef struct {
    string name;
    int n, x, y, hs, de, le, fs, busy;
  } vec_t;
  localparam int SHA = 8, SHF = 2, SHS = 3, SHB = 2, SHT = SHA + SHF + SHS + SHB;
  localparam int SVA = 6, SVF = 1, SVS = 2, SVB = 1, SVT = SVA + SVF + SVS + SVB;
  logic clk = 1'b0, nrst = 1'b0, en_b = 1'b0, en_s = 1'b0;
  logic [10:0] bx, by, sx, sy, zx, zy;
  logic bhs, bvs, bde, bbl, ble, bfs, bbusy;
  logic shs, svs, sde, sbl, sle, sfs, sbusy;
  logic zhs, zvs, zde, zbl, zle, zfs, zbusy;
  obs_t ob, os, os0;
  int n_chk = 0, n_err = 0;
  int bm_mode = 0, bm_p = 0, sm_mode = 0, sm_p = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  t03_display_timing_ctrl u_big (
    .clk(clk), .nrst(nrst), .en(en_b), .x(bx), .y(by), .hsync(bhs), .vsync(bvs), .de(bde),
    .blank(bbl), .line_end(ble), .frame_start(bfs), .busy(bbusy)
  );
  t03_display_timing_ctrl #(.H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB), .SYNC_POL(1'b1)) u_sm (
    .clk(clk), .nrst(nrst), .en(en_s), .x(sx), .y(sy), .hsync(shs), .vsync(svs), .de(sde),
    .blank(sbl), .line_end(sle), .frame_start(sfs), .busy(sbusy)
  );
  t03_display_timing_ctrl #(.H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB), .SYNC_POL(1'b0)) u_sm0 (
    .clk(clk), .nrst(nrst), .en(en_s), .x(zx), .y(zy), .hsync(zhs), .vsync(zvs), .de(zde),
    .blank(zbl), .line_end(zle), .frame_start(zfs), .busy(zbusy)
  );

  assign ob = {bx, by, bhs, bvs, bde, bbl, ble, bfs, bbusy};
  assign os = {sx, sy, shs, svs, sde, sbl, sle, sfs, sbusy};
  assign os0 = {zx, zy, zhs, zvs, zde, zbl, zle, zfs, zbusy};

  // mode: 0 idle, 1 run, 2 stop; p is the linear pixel index y*H_TOTAL+x within the frame
  function automatic obs_t model(int ha, int hf, int hw, int ht, int va, int vf, int vw,
                                 bit pol, int mode, int p);
    obs_t o;
    bit act;
    int cx, cy;
    act = mode != 0;
    if (!act) p = 0;
    cx = p % ht;
    cy = p / ht;
    o.x = 11'(cx);
    o.y = 11'(cy);
    o.hs = (act && cx >= ha + hf && cx < ha + hf + hw) ? pol : !pol;
    o.vs = (act && cy >= va + vf && cy < va + vf + vw) ? pol : !pol;
    o.de = act && cx < ha && cy < va;
    o.bl = !o.de;
    o.le = act && cx == ht - 1;
    o.fs = act && p == 0;
    o.busy = act;
    return o;
  endfunction

  function automatic void step(inout int mode, inout int p, input int ft, input bit e);
    if (mode == 0) begin
      mode = e ? 1 : 0;
      return;
    end
    if (mode == 2 && !e && p == ft - 1) mode = 0;
    else mode = e ? 1 : 2;
    p = (p + 1) % ft;
  endfunction

  task automatic chk(input string nm, input obs_t a, input obs_t e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s got x=%0d y=%0d hs=%b vs=%b de=%b bl=%b le=%b fs=%b busy=%b want x=%0d y=%0d hs=%b vs=%b de=%b bl=%b le=%b fs=%b busy=%b",
               nm, a.x, a.y, a.hs, a.vs, a.de, a.bl, a.le, a.fs, a.busy,
               e.x, e.y, e.hs, e.vs, e.de, e.bl, e.le, e.fs, e.busy);
    end
  endtask

  task automatic chk_int(input string nm, input int a, input int e);
    n_chk++;
    if (a != e) begin
      n_err++;
      $display("FAIL %s got %0d want %0d", nm, a, e);
    end
  endtask

  task automatic check_models(input string tag);
    chk({tag, "/big"}, ob, model(800, 56, 120, 1040, 600, 37, 6, 1'b1, bm_mode, bm_p));
    chk({tag, "/small"}, os, model(SHA, SHF, SHS, SHT, SVA, SVF, SVS, 1'b1, sm_mode, sm_p));
    chk({tag, "/small_pol0"}, os0, model(SHA, SHF, SHS, SHT, SVA, SVF, SVS, 1'b0, sm_mode, sm_p));
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    step(bm_mode, bm_p, 1040 * 666, en_b);
    step(sm_mode, sm_p, SHT * SVT, en_s);
    @(negedge clk);
    check_models(tag);
  endtask

  task automatic do_reset(input string tag);
    nrst = 1'b0;
    #1;
    bm_mode = 0; bm_p = 0; sm_mode = 0; sm_p = 0;
    check_models(tag);
    chk({tag, "/big_const"}, ob, {22'd0, 7'b0001000});
    chk({tag, "/pol0_const"}, os0, {22'd0, 7'b1101000});
  endtask

  task automatic wait_xy(input string nm, input int wx, input int wy);
    int k = 0;
    while (!(int'(sx) == wx && int'(sy) == wy) && k < 300) begin
      cyc(nm);
      k++;
    end
    chk_int({nm, "_reach"}, (int'(sx) == wx && int'(sy) == wy) ? 1 : 0, 1);
  endtask

  initial begin
    int k, de_n, vmin, vmax, v0, le_n, le_x, hs_n, hs_min, hs_max, y_after, px;
    bit seen_le;
    obs_t last;
    tbl.push_back('{"first_run", 1, 0, 0, 0, 1, 0, 1, 1});
    tbl.push_back('{"last_active_x", 799, 799, 0, 0, 1, 0, 0, 1});
    tbl.push_back('{"first_fp_x", 1, 800, 0, 0, 0, 0, 0, 1});
    tbl.push_back('{"hsync_start", 56, 856, 0, 1, 0, 0, 0, 1});
    tbl.push_back('{"hsync_end", 119, 975, 0, 1, 0, 0, 0, 1});
    tbl.push_back('{"hsync_off", 1, 976, 0, 0, 0, 0, 0, 1});
    tbl.push_back('{"line_end", 63, 1039, 0, 0, 0, 1, 0, 1});
    tbl.push_back('{"next_line", 1, 0, 1, 0, 1, 0, 0, 1});
    @(negedge clk);
    do_reset("reset");
    @(negedge clk);
    nrst = 1'b1;
    cyc("idle");
    en_b = 1'b1;
    foreach (tbl[i]) begin
      repeat (tbl[i].n) cyc("line");
      chk(tbl[i].name, ob, {11'(tbl[i].x), 11'(tbl[i].y), tbl[i].hs[0], 1'b0, tbl[i].de[0],
          !tbl[i].de[0], tbl[i].le[0], tbl[i].fs[0], tbl[i].busy[0]});
    end
    le_n = 0; le_x = -1; hs_n = 0; hs_min = 9999; hs_max = -1; y_after = -1; seen_le = 0;
    repeat (1040) begin
      cyc("scan");
      if (seen_le && y_after < 0) y_after = int'(by);
      if (ble) begin le_n++; le_x = int'(bx); seen_le = 1; end
      if (bhs) begin
        hs_n++;
        if (int'(bx) < hs_min) hs_min = int'(bx);
        if (int'(bx) > hs_max) hs_max = int'(bx);
      end
    end
    if (y_after < 0) begin cyc("scan"); y_after = int'(by); end
    chk_int("line_end_count", le_n, 1);
    chk_int("line_end_x", le_x, 1039);
    chk_int("hsync_count", hs_n, 120);
    chk_int("hsync_min_x", hs_min, 856);
    chk_int("hsync_max_x", hs_max, 975);
    chk_int("y_after_line_end", y_after, 2);
    en_s = 1'b1;
    cyc("frame");
    chk_int("frame_fs_first", sfs ? 1 : 0, 1);
    k = 0; de_n = sde ? 1 : 0; vmin = 99; vmax = -1; v0 = zvs ? 0 : 1;
    while (k < 300) begin
      cyc("frame");
      k++;
      if (sfs) break;
      de_n += sde ? 1 : 0;
      v0 += zvs ? 0 : 1;
      if (svs) begin
        if (int'(sy) < vmin) vmin = int'(sy);
        if (int'(sy) > vmax) vmax = int'(sy);
      end
    end
    chk_int("frame_period", k, SHT * SVT);
    chk_int("frame_de_count", de_n, SHA * SVA);
    chk_int("vsync_min_y", vmin, 7);
    chk_int("vsync_max_y", vmax, 8);
    chk_int("pol0_vsync_low_count", v0, SVS * SHT);
    wait_xy("stop", 10, 5);
    en_s = 1'b0;
    k = 0;
    last = os;
    while (sbusy && k < 300) begin
      last = os;
      cyc("stop");
      k++;
    end
    chk_int("stop_drain_cycles", k, 65);
    chk("stop_last_pixel", last, {11'd14, 11'd9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1});
    en_s = 1'b1;
    cyc("resume");
    chk_int("resume_fs", sfs ? 1 : 0, 1);
    repeat (33) cyc("resume");
    px = int'(sx);
    for (int i = 0; i < 4; i++) begin
      en_s = (i != 0);
      cyc("pulse");
      chk_int("pulse_x_cont", int'(sx), (px + 1) % SHT);
      chk_int("pulse_busy", sbusy ? 1 : 0, 1);
      px = int'(sx);
    end
    repeat (160) cyc("pulse_run");
    wait_xy("midreset", 5, 3);
    do_reset("midreset");
    chk("midreset_const", os, {22'd0, 7'b0001000});
    @(negedge clk);
    nrst = 1'b1;
    cyc("restart");
    chk("restart_first", os, {11'd0, 11'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1});
    for (int b = 0; b < 60; b++) begin
      en_s = $urandom_range(0, 1) == 1;
      en_b = $urandom_range(0, 3) != 0;
      repeat ($urandom_range(1, 160)) cyc("rand");
      if ($urandom_range(0, 19) == 0) begin
        do_reset("rand_reset");
        @(negedge clk);
        nrst = 1'b1;
      end
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
